// File: rtl/pedal_ctrl_fsm.sv
// Pedal controller: INIT/PLAY/SET level editor with an optional RECD/LOOP looper sequencer.
// The looper states and its address/length counters are built only when PEDAL_LOOPER_EN is defined.
module pedal_ctrl_fsm #(
   parameter int N_EFF  = 8,
   parameter int LVL_W  = 3,
   parameter int SAT    = 0,
   parameter int ADDR_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_init_done,
   input  logic                     i_key_0,
   input  logic                     i_key_1,
   input  logic                     i_key_2,
   input  logic [$clog2(N_EFF):0]   i_sel,
   input  logic                     i_tick,
   output logic [2:0]               o_state,
   output logic [N_EFF*LVL_W-1:0]   o_levels,
   output logic                     o_cfg_upd,
   output logic                     o_rec_en,
   output logic                     o_play_en,
   output logic [ADDR_W-1:0]        o_loop_addr,
   output logic [ADDR_W:0]          o_loop_len
);

   localparam int SEL_W = $clog2(N_EFF) + 1;
   localparam logic [LVL_W-1:0] LVL_MAX = '1;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_PLAY = 3'd1,
      ST_SET  = 3'd2,
      ST_RECD = 3'd3,
      ST_LOOP = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [N_EFF-1:0][LVL_W-1:0] lvl, lvl_nxt;
   logic                        cfg_upd, upd_nxt;

`ifdef PEDAL_LOOPER_EN
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W:0]   len, len_nxt;
   logic [ADDR_W:0]   rec_cnt;

   // Samples recorded including a tick in this cycle; MSB set means the buffer is full.
   assign rec_cnt = {1'b0, addr} + {{ADDR_W{1'b0}}, i_tick};
`else
   logic looper_unused;
   assign looper_unused = ^{i_key_1, i_tick};
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (i_init_done) state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (i_key_2) state_nxt = ST_SET;
`ifdef PEDAL_LOOPER_EN
            else if (i_key_1) state_nxt = ST_RECD;
`endif
         end
         ST_SET:  if (i_key_2) state_nxt = ST_PLAY;
`ifdef PEDAL_LOOPER_EN
         ST_RECD: begin
            if (rec_cnt[ADDR_W])  state_nxt = ST_LOOP;
            else if (i_key_1)     state_nxt = (rec_cnt == '0) ? ST_PLAY : ST_LOOP;
         end
         ST_LOOP: if (i_key_1) state_nxt = ST_PLAY;
`endif
         default: state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      lvl_nxt = lvl;
      upd_nxt = 1'b0;
      if (state == ST_SET && i_key_0) begin
         for (int unsigned k = 0; k < N_EFF; k++) begin
            if (i_sel == SEL_W'(k)) begin
               if (lvl[k] != LVL_MAX) begin
                  lvl_nxt[k] = lvl[k] + LVL_W'(1);
                  upd_nxt    = 1'b1;
               end else if (SAT == 0) begin
                  lvl_nxt[k] = '0;
                  upd_nxt    = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lvl     <= '0;
         cfg_upd <= 1'b0;
      end else begin
         lvl     <= lvl_nxt;
         cfg_upd <= upd_nxt;
      end
   end

`ifdef PEDAL_LOOPER_EN
   always_comb begin
      addr_nxt = addr;
      len_nxt  = len;
      case (state)
         ST_RECD: begin
            if (rec_cnt[ADDR_W] || i_key_1) begin
               addr_nxt = '0;
               if (rec_cnt != '0) len_nxt = rec_cnt;
            end else begin
               addr_nxt = rec_cnt[ADDR_W-1:0];
            end
         end
         ST_LOOP: begin
            if (i_key_1)
               addr_nxt = '0;
            else if (i_tick)
               addr_nxt = ({1'b0, addr} == len - (ADDR_W+1)'(1)) ? '0 : addr + ADDR_W'(1);
         end
         default: addr_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr <= '0;
         len  <= '0;
      end else begin
         addr <= addr_nxt;
         len  <= len_nxt;
      end
   end
`endif

   always_comb begin
      o_state   = state;
      o_levels  = lvl;
      o_cfg_upd = cfg_upd;
`ifdef PEDAL_LOOPER_EN
      o_rec_en    = (state == ST_RECD);
      o_play_en   = (state == ST_LOOP);
      o_loop_addr = addr;
      o_loop_len  = len;
`else
      o_rec_en    = 1'b0;
      o_play_en   = 1'b0;
      o_loop_addr = '0;
      o_loop_len  = '0;
`endif
   end

endmodule

// File: tb/tb_pedal_ctrl_fsm.sv
// Bench for pedal_ctrl_fsm: a wrapping instance (ADDR_W=3) and a saturating one (ADDR_W=4) share stimulus
// and are compared every cycle against a rule-level model; directed steps first, then random traffic.
module tb_pedal_ctrl_fsm;
   localparam int N_EFF   = 8;
   localparam int LVL_W   = 3;
   localparam int LVL_MAX = (1 << LVL_W) - 1;
`ifdef PEDAL_LOOPER_EN
   localparam bit LOOPER = 1'b1;
`else
   localparam bit LOOPER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       init_done = 1'b0;
   logic       k0 = 1'b0, k1 = 1'b0, k2 = 1'b0, tick = 1'b0;
   logic [3:0] sel = '0;

   logic [2:0]  w_state, s_state;
   logic [23:0] w_levels, s_levels;
   logic        w_upd, s_upd, w_rec, s_rec, w_play, s_play;
   logic [2:0]  w_addr;
   logic [3:0]  w_len;
   logic [3:0]  s_addr;
   logic [4:0]  s_len;

   pedal_ctrl_fsm #(.N_EFF(N_EFF), .LVL_W(LVL_W), .SAT(0), .ADDR_W(3)) u_wrap (
      .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
      .i_key_0(k0), .i_key_1(k1), .i_key_2(k2), .i_sel(sel), .i_tick(tick),
      .o_state(w_state), .o_levels(w_levels), .o_cfg_upd(w_upd),
      .o_rec_en(w_rec), .o_play_en(w_play), .o_loop_addr(w_addr), .o_loop_len(w_len));

   pedal_ctrl_fsm #(.N_EFF(N_EFF), .LVL_W(LVL_W), .SAT(1), .ADDR_W(4)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
      .i_key_0(k0), .i_key_1(k1), .i_key_2(k2), .i_sel(sel), .i_tick(tick),
      .o_state(s_state), .o_levels(s_levels), .o_cfg_upd(s_upd),
      .o_rec_en(s_rec), .o_play_en(s_play), .o_loop_addr(s_addr), .o_loop_len(s_len));

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   int wp = 0, sp = 0;

   // Model: state numbers as on o_state, levels as integers, loop address/length as sample counts.
   int mst[2];
   int mlev[2][N_EFF];
   bit mupd[2];
   int maddr[2];
   int mlen[2];
   int depth[2] = '{8, 16};
   bit msat[2]  = '{1'b0, 1'b1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         mst[m] = 0; mupd[m] = 1'b0; maddr[m] = 0; mlen[m] = 0;
         for (int k = 0; k < N_EFF; k++) mlev[m][k] = 0;
      end
   endfunction

   function automatic void model_step(input int m);
      int cnt;
      int s;
      s = int'(sel);
      mupd[m] = 1'b0;
      case (mst[m])
         0: if (init_done) mst[m] = 1;
         1: begin
            if (k2) mst[m] = 2;
            else if (k1 && LOOPER) begin mst[m] = 3; maddr[m] = 0; end
         end
         2: begin
            if (k0 && s < N_EFF) begin
               if (mlev[m][s] < LVL_MAX) begin mlev[m][s]++; mupd[m] = 1'b1; end
               else if (!msat[m]) begin mlev[m][s] = 0; mupd[m] = 1'b1; end
            end
            if (k2) mst[m] = 1;
         end
         3: begin
            cnt = maddr[m] + int'(tick);
            if (cnt == depth[m]) begin
               mlen[m] = cnt; maddr[m] = 0; mst[m] = 4;
            end else if (k1) begin
               if (cnt == 0) mst[m] = 1;
               else begin mlen[m] = cnt; maddr[m] = 0; mst[m] = 4; end
            end else begin
               maddr[m] = cnt;
            end
         end
         4: begin
            if (k1) begin mst[m] = 1; maddr[m] = 0; end
            else if (tick) maddr[m] = (maddr[m] + 1) % mlen[m];
         end
         default: ;
      endcase
   endfunction

   function automatic logic [63:0] exp_levels(input int m);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < N_EFF; k++) r |= 64'(mlev[m][k]) << (LVL_W * k);
      return r;
   endfunction

   task automatic check_dut(input string p, input int m, input logic [2:0] st, input logic [23:0] lv,
                            input logic upd, input logic rec, input logic play,
                            input logic [63:0] addr, input logic [63:0] len);
      chk({p, "_state"}, 64'(st), 64'(mst[m]));
      chk({p, "_levels"}, 64'(lv), exp_levels(m));
      chk({p, "_cfg_upd"}, 64'(upd), 64'(mupd[m]));
      chk({p, "_rec_en"}, 64'(rec), 64'(mst[m] == 3));
      chk({p, "_play_en"}, 64'(play), 64'(mst[m] == 4));
      chk({p, "_loop_addr"}, addr, 64'(maddr[m]));
      chk({p, "_loop_len"}, len, 64'(mlen[m]));
   endtask

   task automatic check_all();
      check_dut("w", 0, w_state, w_levels, w_upd, w_rec, w_play, 64'(w_addr), 64'(w_len));
      check_dut("s", 1, s_state, s_levels, s_upd, s_rec, s_play, 64'(s_addr), 64'(s_len));
   endtask

   task automatic step(input bit a0, input bit a1, input bit a2, input logic [3:0] asel, input bit at);
      k0 = a0; k1 = a1; k2 = a2; sel = asel; tick = at;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      if (w_upd) wp++;
      if (s_upd) sp++;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   // Reset lands between clock edges so its effect must be visible without any edge.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      k0 = 1'b0; k1 = 1'b0; k2 = 1'b0; tick = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int seq[12];
      seq = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};

      #1;
      model_reset();
      check_all();
      chk("rst_state", 64'(w_state), 64'd0);
      chk("rst_len", 64'(w_len), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Keys in INIT are ignored while init_done is low.
      for (int i = 0; i < 5; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd3, 1'b1);
      chk("init_hold", 64'(w_state), 64'd0);
      init_done = 1'b1;
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("init_play", 64'(w_state), 64'd1);
      chk("init_levels", 64'(w_levels), 64'd0);

      step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
      chk("enter_set", 64'(s_state), 64'd2);
      wp = 0; sp = 0;
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
      chk("wrap_pulses", 64'(wp), 64'd9);
      chk("sat_pulses", 64'(sp), 64'd7);
      chk("wrap_level3", 64'(w_levels), 64'h000200);
      chk("sat_level3", 64'(s_levels), 64'h000E00);

      step(1'b1, 1'b0, 1'b0, 4'd8, 1'b0);
      chk("sel_oob_upd", 64'(w_upd), 64'd0);
      step(1'b1, 1'b0, 1'b0, 4'd15, 1'b0);
      chk("sel_oob_levels", 64'(w_levels), 64'h000200);

      // Increment and exit in the same cycle.
      step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
      chk("inc_exit_state", 64'(w_state), 64'd1);
      chk("inc_exit_level", 64'(s_levels), 64'h000E01);

      if (LOOPER) begin
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         chk("recd_rec_en", 64'(w_rec), 64'd1);
         for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            idle(1);
         end
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         chk("loop_len5", 64'(w_len), 64'd5);
         chk("loop_state", 64'(w_state), 64'd4);
         for (int i = 0; i < 12; i++) begin
            step(i == 3, 1'b0, i == 6, 4'd1, 1'b1);
            chk("loop_addr_seq", 64'(w_addr), 64'(seq[i]));
         end
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         chk("loop_exit_len", 64'(s_len), 64'd5);

         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
         chk("auto_loop_state", 64'(w_state), 64'd4);
         chk("auto_loop_len", 64'(w_len), 64'd8);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         chk("empty_rec_state", 64'(w_state), 64'd1);
         chk("empty_rec_len", 64'(w_len), 64'd8);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         chk("empty_rec_len_s", 64'(s_len), 64'd8);

         async_reset();
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
         for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
         chk("tick_with_key_len", 64'(w_len), 64'd5);
         for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
         chk("pre_rst_addr", 64'(w_addr), 64'd3);
         async_reset();
         chk("rst_loop_state", 64'(w_state), 64'd0);
         chk("rst_loop_play", 64'(w_play), 64'd0);
         chk("rst_loop_len", 64'(w_len), 64'd0);
      end else begin
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
         chk("key1_ignored", 64'(w_state), 64'd1);
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
         chk("key1_ignored_rec", 64'(s_rec), 64'd0);
         async_reset();
      end

      // After reset the block waits for init_done again.
      init_done = 1'b0;
      idle(3);
      chk("rewait_init", 64'(w_state), 64'd0);
      init_done = 1'b1;
      idle(1);
      chk("rewait_play", 64'(w_state), 64'd1);

      for (int i = 0; i < 3000; i++) begin
         init_done = ($urandom_range(0, 15) != 0);
         step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 399) == 0) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
